// File: rtl/bsg_manycore_pkg.sv
// Shared manycore definitions used by the remote-store encode pipe:
// packet opcodes and the default register-id width.
package bsg_manycore_pkg;

  localparam int unsigned bsg_manycore_reg_id_width_gp = 5;

  typedef enum logic [1:0] {
    e_remote_load  = 2'b00,
    e_remote_store = 2'b01,
    e_remote_amo   = 2'b10,
    e_remote_sw    = 2'b11
  } bsg_manycore_packet_op_e;

  // Lane fill byte for a disabled lane: register id zero-extended to 8 bits.
  function automatic logic [7:0] store_encode_fill(input logic [7:0] reg_id_ext);
    return reg_id_ext;
  endfunction

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small 1-read/1-write FIFO (1 or 2 entries) with valid/ready in and
// valid/yumi out; a same-cycle dequeue frees a slot for the incoming write.
module bsg_fifo_1r1w_small #(
  parameter int unsigned width_p = 8,
  parameter int unsigned els_p   = 2
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_v,
  output logic               o_ready,
  input  logic [width_p-1:0] i_data,
  output logic               o_v,
  output logic [width_p-1:0] o_data,
  input  logic               i_yumi
);

  logic [width_p-1:0] r_mem [2];
  logic               r_wr_ptr;
  logic               r_rd_ptr;
  logic [1:0]         r_count;

  logic w_full;
  logic w_enq;
  logic w_deq;
  logic w_wr_ptr_next;
  logic w_rd_ptr_next;

  assign w_full        = (r_count == 2'(els_p));
  assign o_v           = (r_count != 2'd0);
  assign w_deq         = i_yumi & o_v;
  assign o_ready       = !w_full || w_deq;
  assign w_enq         = i_v & o_ready;
  assign o_data        = r_mem[r_rd_ptr];
  // Single-entry configuration pins both pointers to slot 0.
  assign w_wr_ptr_next = (els_p == 2) ? ~r_wr_ptr : 1'b0;
  assign w_rd_ptr_next = (els_p == 2) ? ~r_rd_ptr : 1'b0;

  always_ff @(posedge i_clk) begin
    if (w_enq) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_enq) r_wr_ptr <= w_wr_ptr_next;
      if (w_deq) r_rd_ptr <= w_rd_ptr_next;
      r_count <= r_count + 2'(w_enq) - 2'(w_deq);
    end
  end

endmodule

// File: rtl/bsg_manycore_store_encode_lanes.sv
// Combinational remote-store encoder: full-word stores pass through as
// e_remote_sw, partial stores carry the mask in reg_id and reg_id in idle lanes.
module bsg_manycore_store_encode_lanes
  import bsg_manycore_pkg::*;
#(
  parameter  int unsigned data_width_p   = 32,
  parameter  int unsigned reg_id_width_p = bsg_manycore_reg_id_width_gp,
  localparam int unsigned mask_width_lp  = data_width_p / 8
) (
  input  logic [data_width_p-1:0]   i_data,
  input  logic [mask_width_lp-1:0]  i_mask,
  input  logic [reg_id_width_p-1:0] i_reg_id,
  output logic [data_width_p-1:0]   o_data,
  output logic [reg_id_width_p-1:0] o_reg_id,
  output bsg_manycore_packet_op_e   o_op
);

  logic       w_full_word;
  logic [7:0] w_fill;

  assign w_full_word = &i_mask;
  assign w_fill      = store_encode_fill(8'(i_reg_id));

  always_comb begin
    o_data   = '0;
    o_reg_id = i_reg_id;
    o_op     = e_remote_sw;
    for (int unsigned b = 0; b < mask_width_lp; b++) begin
      o_data[8*b +: 8] = (w_full_word || i_mask[b]) ? i_data[8*b +: 8] : w_fill;
    end
    if (!w_full_word) begin
      o_reg_id = reg_id_width_p'(i_mask);
      o_op     = e_remote_store;
    end
  end

endmodule

// File: rtl/bsg_manycore_store_encode_pipe.sv
// Buffered remote-store encoder: encodes at enqueue, holds encoded requests in a
// small FIFO. Define BSG_MANYCORE_STORE_ENCODE_STATS_EN for saturating counters.
module bsg_manycore_store_encode_pipe
  import bsg_manycore_pkg::*;
#(
  parameter  int unsigned data_width_p   = 32,
  parameter  int unsigned reg_id_width_p = bsg_manycore_reg_id_width_gp,
  parameter  int unsigned els_p          = 2,
  localparam int unsigned mask_width_lp  = data_width_p / 8
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      v_i,
  input  logic [data_width_p-1:0]   data_i,
  input  logic [mask_width_lp-1:0]  mask_i,
  input  logic [reg_id_width_p-1:0] reg_id_i,
  output logic                      ready_o,
  output logic                      v_o,
  output logic [data_width_p-1:0]   data_o,
  output logic [reg_id_width_p-1:0] reg_id_o,
  output bsg_manycore_packet_op_e   op_o,
  input  logic                      yumi_i,
  output logic                      err_zero_mask_o
`ifdef BSG_MANYCORE_STORE_ENCODE_STATS_EN
  ,
  output logic [31:0]               sw_count_o,
  output logic [31:0]               store_count_o,
  output logic [31:0]               drop_count_o
`endif
);

  typedef struct packed {
    logic [data_width_p-1:0]   data;
    logic [reg_id_width_p-1:0] reg_id;
    bsg_manycore_packet_op_e   op;
  } store_encode_s;

  if ((data_width_p % 8) != 0 || data_width_p < 16 || data_width_p > 64) begin : g_bad_data_width
    $error("data_width_p must be a multiple of 8 in 16..64");
  end
  if (reg_id_width_p < mask_width_lp + 1 || reg_id_width_p > 8) begin : g_bad_reg_id_width
    $error("reg_id_width_p must be in mask_width_lp+1..8");
  end
  if (els_p != 1 && els_p != 2) begin : g_bad_els
    $error("els_p must be 1 or 2");
  end

  store_encode_s w_enc;
  store_encode_s w_head;
  logic          w_fifo_ready;
  logic          w_fifo_v;
  logic          w_accept;
  logic          w_zero_mask;
  logic          r_err_zero_mask;

  bsg_manycore_store_encode_lanes #(
    .data_width_p   (data_width_p),
    .reg_id_width_p (reg_id_width_p)
  ) u_lanes (
    .i_data   (data_i),
    .i_mask   (mask_i),
    .i_reg_id (reg_id_i),
    .o_data   (w_enc.data),
    .o_reg_id (w_enc.reg_id),
    .o_op     (w_enc.op)
  );

  // Zero-mask requests complete the handshake but are never buffered.
  assign w_zero_mask = (mask_i == '0);
  assign ready_o     = !reset_i && w_fifo_ready;
  assign w_accept    = v_i && ready_o;

  bsg_fifo_1r1w_small #(
    .width_p (($bits(store_encode_s))),
    .els_p   (els_p)
  ) u_fifo (
    .i_clk   (clk_i),
    .i_reset (reset_i),
    .i_v     (w_accept && !w_zero_mask),
    .o_ready (w_fifo_ready),
    .i_data  (w_enc),
    .o_v     (w_fifo_v),
    .o_data  (w_head),
    .i_yumi  (yumi_i)
  );

  assign v_o             = w_fifo_v && !reset_i;
  assign data_o          = w_head.data;
  assign reg_id_o        = w_head.reg_id;
  assign op_o            = w_head.op;
  assign err_zero_mask_o = r_err_zero_mask;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_err_zero_mask <= 1'b0;
    end else if (w_accept && w_zero_mask) begin
      r_err_zero_mask <= 1'b1;
    end
  end

`ifdef BSG_MANYCORE_STORE_ENCODE_STATS_EN
  logic [31:0] r_sw_count;
  logic [31:0] r_store_count;
  logic [31:0] r_drop_count;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_sw_count    <= '0;
      r_store_count <= '0;
      r_drop_count  <= '0;
    end else begin
      if (yumi_i && v_o && op_o == e_remote_sw && r_sw_count != '1) begin
        r_sw_count <= r_sw_count + 32'd1;
      end
      if (yumi_i && v_o && op_o == e_remote_store && r_store_count != '1) begin
        r_store_count <= r_store_count + 32'd1;
      end
      if (w_accept && w_zero_mask && r_drop_count != '1) begin
        r_drop_count <= r_drop_count + 32'd1;
      end
    end
  end

  assign sw_count_o    = r_sw_count;
  assign store_count_o = r_store_count;
  assign drop_count_o  = r_drop_count;
`endif

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!$isunknown(v_i) && !$isunknown(yumi_i));
      assert (!(yumi_i && !v_o));
    end
  end

endmodule
